sampselect_rr: RTL and testbench

Parametrised multi-source sample arbiter feeding the sample queue. Each source has a small FIFO that absorbs bursts, so up to DEPTH simultaneous samples per source are kept rather than overwritten. A fair round-robin arbiter drains the FIFOs into a registered valid/ready output toward the queue writer. Per-source saturating drop counters make overruns visible to host software.

---
 rtl/sampq_pkg.sv | 13 +
 rtl/sampfifo.sv | 49 ++++
 rtl/sampselect_rr.sv | 125 ++++++++++++
 tb/tb_sampselect_rr.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sampq_pkg.sv
// Shared definitions for the sample-queue blocks: default widths and the
// source-index width helper.
package sampq_pkg;

    localparam int SAMPQ_WIDTH     = 32;
    localparam int SAMPQ_CNT_WIDTH = 8;

    // Width of a source index; a single source still gets a 1-bit field.
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sampfifo.sv
// Small per-source sample FIFO. Pointers carry one extra wrap bit, so
// full and empty can be told apart without a separate counter.
module sampfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush empties the FIFO just like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sampselect_rr.sv
// Multi-source sample arbiter: per-source FIFOs drained round-robin into a
// registered valid/ready output, with saturating per-source drop counters.
module sampselect_rr
    import sampq_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int WIDTH       = SAMPQ_WIDTH,
    parameter int DEPTH       = 2,
    parameter int CNT_WIDTH   = SAMPQ_CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sq_active,
    input  logic [WIDTH*NUM_SOURCES-1:0]     sources,
    input  logic [NUM_SOURCES-1:0]           avails,
    output logic [WIDTH-1:0]                 sample,
    output logic [src_w(NUM_SOURCES)-1:0]    sample_src,
    output logic                             sample_avail,
    input  logic                             sample_ready,
    output logic [CNT_WIDTH*NUM_SOURCES-1:0] drops
);

    localparam int          SRC_W = src_w(NUM_SOURCES);
    localparam int unsigned N     = NUM_SOURCES;

    logic [NUM_SOURCES-1:0] w_empty;
    logic [NUM_SOURCES-1:0] w_full;
    logic [NUM_SOURCES-1:0] w_push;
    logic [NUM_SOURCES-1:0] w_pop;
    logic [NUM_SOURCES-1:0] w_drop;
    logic [WIDTH-1:0]       w_dout [NUM_SOURCES];
    logic                   w_flush;
    logic                   w_load;
    logic                   w_found;
    logic                   w_grant;
    logic [SRC_W-1:0]       w_gnt;
    logic [SRC_W-1:0]       w_cand;
    int unsigned            w_idx;

    logic [WIDTH-1:0]       r_sample;
    logic [SRC_W-1:0]       r_src;
    logic                   r_avail;
    logic [SRC_W-1:0]       r_rr_last;

    assign w_flush      = !sq_active;
    assign w_load       = !r_avail || sample_ready;
    assign w_grant      = sq_active && w_load && w_found;
    assign sample       = r_sample;
    assign sample_src   = r_src;
    assign sample_avail = r_avail;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        logic [CNT_WIDTH-1:0] r_drop;

        // A full FIFO still accepts when it is popped in the same cycle.
        assign w_pop[g]  = w_grant && (w_gnt == SRC_W'(g));
        assign w_push[g] = sq_active && avails[g] && (!w_full[g] || w_pop[g]);
        assign w_drop[g] = sq_active && avails[g] && w_full[g] && !w_pop[g];
        assign drops[g*CNT_WIDTH +: CNT_WIDTH] = r_drop;

        sampfifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (w_flush),
            .push  (w_push[g]),
            .din   (sources[g*WIDTH +: WIDTH]),
            .pop   (w_pop[g]),
            .dout  (w_dout[g]),
            .empty (w_empty[g]),
            .full  (w_full[g])
        );

        // Saturating count of refused samples; cleared while inactive.
        always_ff @(posedge clk) begin
            if (rst || !sq_active) begin
                r_drop <= '0;
            end else if (w_drop[g] && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // Round-robin search: first non-empty FIFO after the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            w_idx = 32'(r_rr_last) + off;
            if (w_idx >= N) w_idx = w_idx - N;
            w_cand = SRC_W'(w_idx);
            if (!w_found && !w_empty[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    // Output register and arbiter pointer; holds while stalled by the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample  <= '0;
            r_src     <= '0;
            r_avail   <= 1'b0;
            r_rr_last <= SRC_W'(N - 1);
        end else if (!sq_active) begin
            r_avail   <= 1'b0;
            r_rr_last <= SRC_W'(N - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_sample  <= w_dout[w_gnt];
                r_src     <= w_gnt;
                r_avail   <= 1'b1;
                r_rr_last <= w_gnt;
            end else begin
                r_avail   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sampselect_rr.sv
// Directed bench for sampselect_rr with a scoreboard of expected transfers.
module tb_sampselect_rr;

    localparam int NS = 4;
    localparam int W  = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           sq_active;
    logic [W*NS-1:0] sources;
    logic [NS-1:0]  avails;
    logic [W-1:0]   sample;
    logic [1:0]     sample_src;
    logic           sample_avail;
    logic           sample_ready;
    logic [CW*NS-1:0] drops;

    exp_t sb[$];
    exp_t e;
    int   n_asserts = 0;
    int   n_fail    = 0;
    logic [W-1:0] held;

    sampselect_rr #(
        .NUM_SOURCES (NS),
        .WIDTH       (W),
        .DEPTH       (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sq_active    (sq_active),
        .sources      (sources),
        .avails       (avails),
        .sample       (sample),
        .sample_src   (sample_src),
        .sample_avail (sample_avail),
        .sample_ready (sample_ready),
        .drops        (drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] s, input logic [W-1:0] d);
        e.src  = s;
        e.data = d;
        sb.push_back(e);
    endtask

    // One clock: at the falling edge score any transfer, then step past the rising edge.
    task automatic cycle();
        exp_t x;
        @(negedge clk);
        if (sample_avail && sample_ready) begin
            n_asserts++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed sample %0h src %0d, expected no transfer", sample, sample_src);
            end
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("sb_data", 64'(sample), 64'(x.data));
                chk("sb_src", 64'(sample_src), 64'(x.src));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic setsrc(input int i, input logic [W-1:0] d);
        sources[i*W +: W] = d;
    endtask

    function automatic logic [CW-1:0] drop_of(input int i);
        return drops[i*CW +: CW];
    endfunction

    initial begin
        rst = 1'b1; sq_active = 1'b1; sources = '0; avails = '0; sample_ready = 1'b1;
        cycles(2);
        chk("rst_sample", 64'(sample), 64'h0);
        chk("rst_src", 64'(sample_src), 64'h0);
        chk("rst_avail", 64'(sample_avail), 64'h0);
        chk("rst_drops", 64'(drops), 64'h0);
        rst = 1'b0;
        cycle();

        // Single sample: visible two cycles after the strobe.
        setsrc(0, 32'hA5A5A5A5); avails = 4'b0001; push_exp(2'd0, 32'hA5A5A5A5);
        cycle();
        avails = '0;
        chk("lat_n1_avail", 64'(sample_avail), 64'h0);
        cycle();
        chk("lat_n2_avail", 64'(sample_avail), 64'h1);
        chk("lat_n2_sample", 64'(sample), 64'hA5A5A5A5);
        chk("lat_n2_src", 64'(sample_src), 64'h0);
        chk("lat_n2_drops", 64'(drops), 64'h0);
        cycle();
        chk("lat_n3_avail", 64'(sample_avail), 64'h0);

        // Inactive pulse returns the arbiter pointer to the last source.
        sq_active = 1'b0; cycle(); sq_active = 1'b1; cycle();

        // Fairness: all sources at once drain 0,1,2,3.
        for (int i = 0; i < NS; i++) begin
            setsrc(i, 32'h10 + i);
            push_exp(2'(i), 32'h10 + i);
        end
        avails = 4'b1111;
        cycle();
        avails = '0;
        cycle();
        chk("fair_first_src", 64'(sample_src), 64'h0);
        cycles(6);

        // Grant source 2 alone, then the next full round starts at source 3.
        setsrc(2, 32'h22); avails = 4'b0100; push_exp(2'd2, 32'h22);
        cycle(); avails = '0; cycles(4);
        for (int i = 0; i < NS; i++) setsrc(i, 32'h30 + i);
        push_exp(2'd3, 32'h33); push_exp(2'd0, 32'h30);
        push_exp(2'd1, 32'h31); push_exp(2'd2, 32'h32);
        avails = 4'b1111;
        cycle(); avails = '0; cycles(7);
        chk("fair_sb_empty", 64'(sb.size()), 64'h0);

        // Overflow: 5 strobes into a stalled source 1 keep 3, drop 2.
        sample_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            setsrc(1, 32'h100 + k); avails = 4'b0010;
            cycle();
        end
        avails = '0;
        push_exp(2'd1, 32'h100); push_exp(2'd1, 32'h101); push_exp(2'd1, 32'h102);
        chk("ovf_drops1", 64'(drop_of(1)), 64'h2);
        chk("ovf_drops0", 64'(drop_of(0)), 64'h0);
        chk("ovf_sample", 64'(sample), 64'h100);
        chk("ovf_src", 64'(sample_src), 64'h1);

        // Backpressure: output held stable for 10 stalled cycles.
        held = sample;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("bp_sample", 64'(sample), 64'(held));
            chk("bp_src", 64'(sample_src), 64'h1);
            chk("bp_avail", 64'(sample_avail), 64'h1);
        end

        // Drop counter saturation.
        setsrc(1, 32'hDEAD); avails = 4'b0010;
        cycles(300);
        avails = '0;
        chk("sat_drops1", 64'(drop_of(1)), 64'hFF);

        // Drain in order after releasing backpressure.
        sample_ready = 1'b1;
        cycles(6);
        chk("drain_sb_empty", 64'(sb.size()), 64'h0);
        chk("drain_avail", 64'(sample_avail), 64'h0);

        // Flush clears counters; then full FIFO pushed and popped together drops nothing.
        sq_active = 1'b0; cycle(); sq_active = 1'b1;
        chk("clr_drops", 64'(drops), 64'h0);
        sample_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) sample_ready = 1'b1;
            setsrc(1, 32'h200 + k); avails = 4'b0010;
            push_exp(2'd1, 32'h200 + k);
            cycle();
        end
        avails = '0;
        chk("pp_drops1", 64'(drop_of(1)), 64'h0);
        cycles(6);
        chk("pp_sb_empty", 64'(sb.size()), 64'h0);

        // Flush with data buffered in three FIFOs; nothing of it may appear.
        sample_ready = 1'b0;
        setsrc(0, 32'h300); setsrc(1, 32'h301); setsrc(2, 32'h302);
        avails = 4'b0111; cycle();
        avails = 4'b0001; cycles(5);
        chk("fl_pre_drops", 64'(|drops), 64'h1);
        for (int i = 0; i < NS; i++) setsrc(i, 32'h400 + i);
        avails = 4'b1111; sq_active = 1'b0;
        cycle();
        avails = '0; sq_active = 1'b1;
        chk("fl_avail", 64'(sample_avail), 64'h0);
        chk("fl_drops", 64'(drops), 64'h0);
        sample_ready = 1'b1;
        cycles(6);
        chk("fl_no_output", 64'(sample_avail), 64'h0);

        // Reset mid-stream during a transfer with pushes pending.
        for (int i = 0; i < NS; i++) setsrc(i, 32'h500 + i);
        avails = 4'b1111; cycle();
        for (int i = 0; i < NS; i++) setsrc(i, 32'h510 + i);
        cycle();
        push_exp(2'd0, 32'h500);
        for (int i = 0; i < NS; i++) setsrc(i, 32'h520 + i);
        rst = 1'b1;
        cycle();
        rst = 1'b0; avails = '0;
        chk("mrst_sample", 64'(sample), 64'h0);
        chk("mrst_src", 64'(sample_src), 64'h0);
        chk("mrst_avail", 64'(sample_avail), 64'h0);
        chk("mrst_drops", 64'(drops), 64'h0);
        chk("mrst_sb_empty", 64'(sb.size()), 64'h0);
        cycle();
        chk("mrst_idle", 64'(sample_avail), 64'h0);

        // First sample after reset keeps the 2-cycle latency.
        setsrc(2, 32'h600); avails = 4'b0100; push_exp(2'd2, 32'h600);
        cycle();
        avails = '0;
        chk("post_n1_avail", 64'(sample_avail), 64'h0);
        cycle();
        chk("post_n2_avail", 64'(sample_avail), 64'h1);
        chk("post_n2_sample", 64'(sample), 64'h600);
        chk("post_n2_src", 64'(sample_src), 64'h2);
        cycles(3);
        chk("end_sb_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
